// File: rtl/mc_control_fsm_if.sv
// Controller-to-datapath bundle for the multi-cycle control FSM.
// The controller side takes the instruction fields, ALU zero flag and memory
// handshake, and drives the datapath enables, selects and status outputs.
interface mc_control_fsm_if #(
    parameter int RETIRE_W = 32
);
    logic [6:0]          i_opcode;
    logic [2:0]          i_funct3;
    logic                i_funct7bit5;
    logic                i_zeroFlag;
    logic                i_memReady;

    logic                o_pcWriteEn;
    logic                o_instructionRegWrite;
    logic                o_regWriteEn;
    logic                o_memWriteEn;
    logic                o_memReadEn;
    logic                o_addressSrc;
    logic [1:0]          o_aluInputASel;
    logic [1:0]          o_aluInputBSel;
    logic [3:0]          o_aluLogicOperation;
    logic [1:0]          o_resultSel;
    logic                o_trap;
    logic [RETIRE_W-1:0] o_retireCount;

    // Controller side.
    modport master (
        input  i_opcode, i_funct3, i_funct7bit5, i_zeroFlag, i_memReady,
        output o_pcWriteEn, o_instructionRegWrite, o_regWriteEn, o_memWriteEn,
               o_memReadEn, o_addressSrc, o_aluInputASel, o_aluInputBSel,
               o_aluLogicOperation, o_resultSel, o_trap, o_retireCount
    );

    // Datapath side.
    modport slave (
        output i_opcode, i_funct3, i_funct7bit5, i_zeroFlag, i_memReady,
        input  o_pcWriteEn, o_instructionRegWrite, o_regWriteEn, o_memWriteEn,
               o_memReadEn, o_addressSrc, o_aluInputASel, o_aluInputBSel,
               o_aluLogicOperation, o_resultSel, o_trap, o_retireCount
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32 subset control FSM (lw, sw, R/I ALU ops, beq/bne, jal).
// Datapath controls are decoded from the current state and live inputs, so
// memory-ready and zero-flag reactions happen in the same cycle. Memory waits
// are bounded by MEM_TIMEOUT; illegal instructions and timeouts park in TRAP.
module mc_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int FULL_BRANCH = 1,
    parameter int RETIRE_W    = 32
) (
    input logic              i_clk,
    input logic              i_srst,
    mc_control_fsm_if.master bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;

    localparam logic [1:0] A_PC = 2'd0, A_OLD_PC = 2'd1, A_RS1 = 2'd2;
    localparam logic [1:0] B_RS2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2;
    localparam logic [1:0] RES_ALU_Q = 2'd0, RES_DATA_Q = 2'd1, RES_ALU_D = 2'd2;

    // The wait counter only needs to reach MEM_TIMEOUT-1: the cycle that would
    // make it MEM_TIMEOUT is the timeout cycle itself.
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST =
        (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

    state_t              state;
    logic [CNT_W-1:0]    wait_cnt;
    logic [RETIRE_W-1:0] retire_cnt;

    logic       in_wait_state, timeout_hit;
    logic       f3_ok;
    logic [3:0] f3_op;
    logic       br_eq, br_ne, br_legal, br_taken;

    logic       pc_we, ir_we, reg_we, mem_we, mem_re, addr_src;
    logic [1:0] a_sel, b_sel, result_sel;
    logic [3:0] alu_op;

    assign in_wait_state = state inside {FETCH, MEMREAD, MEMWRITE};
    assign timeout_hit   = (MEM_TIMEOUT != 0) && in_wait_state &&
                           !bus.i_memReady && (wait_cnt == WAIT_LAST);

    assign br_eq    = (bus.i_funct3 == 3'b000);
    assign br_ne    = (FULL_BRANCH != 0) && (bus.i_funct3 == 3'b001);
    assign br_legal = br_eq || br_ne;
    assign br_taken = (br_eq && bus.i_zeroFlag) || (br_ne && !bus.i_zeroFlag);

    // funct3 to ALU operation; funct7bit5 selects SUB only for register ops.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        f3_ok = 1'b1;
        f3_op = ALU_ADD;
        case (bus.i_funct3)
            3'b000:  f3_op = (state == EXECR && bus.i_funct7bit5) ? ALU_SUB : ALU_ADD;
            3'b111:  f3_op = ALU_AND;
            3'b110:  f3_op = ALU_OR;
            3'b010:  f3_op = ALU_SLT;
            default: f3_ok = 1'b0;
        endcase
    end

    // State transitions, memory wait counting and retirement counting.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments throughout, so every flop samples the values from before this edge.
        if (i_srst) begin
            state      <= FETCH;
            wait_cnt   <= '0;
            retire_cnt <= '0;
        end else begin
            // Any state change clears the counter; only a held wait state advances it.
            wait_cnt <= '0;
            case (state)
                FETCH: begin
                    if (timeout_hit)           state    <= TRAP;
                    else if (bus.i_memReady)   state    <= DECODE;
                    else                       wait_cnt <= wait_cnt + 1'b1;
                end
                DECODE: begin
                    case (bus.i_opcode)
                        OPC_LOAD, OPC_STORE: state <= MEMADR;
                        OPC_OP:              state <= EXECR;
                        OPC_OPIMM:           state <= EXECI;
                        OPC_BRANCH:          state <= BRANCH;
                        OPC_JAL:             state <= JAL;
                        default:             state <= TRAP;
                    endcase
                end
                MEMADR:  state <= (bus.i_opcode == OPC_STORE) ? MEMWRITE : MEMREAD;
                MEMREAD: begin
                    if (timeout_hit)           state    <= TRAP;
                    else if (bus.i_memReady)   state    <= MEMWB;
                    else                       wait_cnt <= wait_cnt + 1'b1;
                end
                MEMWRITE: begin
                    if (timeout_hit) begin
                        state <= TRAP;
                    end else if (bus.i_memReady) begin
                        state      <= FETCH;
                        retire_cnt <= retire_cnt + 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                MEMWB, ALUWB, JAL: begin
                    state      <= FETCH;
                    retire_cnt <= retire_cnt + 1'b1;
                end
                EXECR, EXECI: state <= f3_ok ? ALUWB : TRAP;
                BRANCH: begin
                    if (br_legal) begin
                        state      <= FETCH;
                        retire_cnt <= retire_cnt + 1'b1;
                    end else begin
                        state <= TRAP;
                    end
                end
                default: state <= TRAP;
            endcase
        end
    end

    // Datapath controls from the current state; reset and a timeout cycle silence everything.
    always_comb begin
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        addr_src   = 1'b0;
        a_sel      = A_PC;
        b_sel      = B_RS2;
        alu_op     = ALU_ADD;
        result_sel = RES_ALU_Q;
        if (!i_srst && !timeout_hit) begin
            case (state)
                FETCH: begin
                    mem_re = 1'b1;
                    a_sel  = A_PC;
                    b_sel  = B_FOUR;
                    if (bus.i_memReady) begin
                        ir_we      = 1'b1;
                        pc_we      = 1'b1;
                        result_sel = RES_ALU_D;
                    end
                end
                DECODE: begin
                    a_sel = A_OLD_PC;
                    b_sel = B_IMM;
                end
                MEMADR: begin
                    a_sel = A_RS1;
                    b_sel = B_IMM;
                end
                MEMREAD: begin
                    mem_re   = 1'b1;
                    addr_src = 1'b1;
                end
                MEMWRITE: begin
                    mem_we   = 1'b1;
                    addr_src = 1'b1;
                end
                MEMWB: begin
                    reg_we     = 1'b1;
                    result_sel = RES_DATA_Q;
                end
                EXECR: begin
                    a_sel  = A_RS1;
                    b_sel  = B_RS2;
                    alu_op = f3_op;
                end
                EXECI: begin
                    a_sel  = A_RS1;
                    b_sel  = B_IMM;
                    alu_op = f3_op;
                end
                ALUWB: reg_we = 1'b1;
                BRANCH: begin
                    a_sel  = A_RS1;
                    b_sel  = B_RS2;
                    alu_op = ALU_SUB;
                    pc_we  = br_taken;
                end
                JAL: begin
                    a_sel  = A_OLD_PC;
                    b_sel  = B_FOUR;
                    pc_we  = 1'b1;
                    reg_we = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_pcWriteEn           = pc_we;
    assign bus.o_instructionRegWrite = ir_we;
    assign bus.o_regWriteEn          = reg_we;
    assign bus.o_memWriteEn          = mem_we;
    assign bus.o_memReadEn           = mem_re;
    assign bus.o_addressSrc          = addr_src;
    assign bus.o_aluInputASel        = a_sel;
    assign bus.o_aluInputBSel        = b_sel;
    assign bus.o_aluLogicOperation   = alu_op;
    assign bus.o_resultSel           = result_sel;
    assign bus.o_trap                = (state == TRAP);
    assign bus.o_retireCount         = retire_cnt;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed instruction sequences plus
// a random instruction stream, compared cycle by cycle against an expected
// control trace built per instruction from the instruction's phase list.
module tb_mc_control_fsm;
    localparam int TIMEOUT = 16;
    localparam int FB      = 0;
    localparam int RW      = 4;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Control word: {pcWE, irWE, regWE, memWE, memRE, addrSrc, A, B, op, resultSel, trap}
    localparam logic [16:0] ALL     = 17'h1FFFF;
    localparam logic [16:0] EN_MASK = 17'h1F800;
    localparam logic [16:0] W_FETCH_WAIT = {6'b000010, 2'd0, 2'd2, 4'd0, 2'd0, 1'b0};
    localparam logic [16:0] W_FETCH_DONE = {6'b110010, 2'd0, 2'd2, 4'd0, 2'd2, 1'b0};
    localparam logic [16:0] W_DECODE     = {6'b000000, 2'd1, 2'd1, 4'd0, 2'd0, 1'b0};
    localparam logic [16:0] W_MEMADR     = {6'b000000, 2'd2, 2'd1, 4'd0, 2'd0, 1'b0};
    localparam logic [16:0] W_MEMREAD    = {6'b000011, 2'd0, 2'd0, 4'd0, 2'd0, 1'b0};
    localparam logic [16:0] W_MEMWRITE   = {6'b000101, 2'd0, 2'd0, 4'd0, 2'd0, 1'b0};
    localparam logic [16:0] W_MEMWB      = {6'b001000, 2'd0, 2'd0, 4'd0, 2'd1, 1'b0};
    localparam logic [16:0] W_ALUWB      = {6'b001000, 2'd0, 2'd0, 4'd0, 2'd0, 1'b0};
    localparam logic [16:0] W_JAL        = {6'b101000, 2'd1, 2'd2, 4'd0, 2'd0, 1'b0};
    localparam logic [16:0] W_TRAP       = {6'b000000, 2'd0, 2'd0, 4'd0, 2'd0, 1'b1};

    logic i_clk = 1'b0;
    logic i_srst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_retire = 0;

    always #5 i_clk = ~i_clk;

    mc_control_fsm_if #(.RETIRE_W(RW)) bus ();

    mc_control_fsm #(
        .MEM_TIMEOUT(TIMEOUT),
        .FULL_BRANCH(FB),
        .RETIRE_W   (RW)
    ) dut (
        .i_clk (i_clk),
        .i_srst(i_srst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] observed();
        return {bus.o_pcWriteEn, bus.o_instructionRegWrite, bus.o_regWriteEn,
                bus.o_memWriteEn, bus.o_memReadEn, bus.o_addressSrc,
                bus.o_aluInputASel, bus.o_aluInputBSel, bus.o_aluLogicOperation,
                bus.o_resultSel, bus.o_trap};
    endfunction

    function automatic logic rbit();
        return $urandom_range(0, 1) == 1;
    endfunction

    // {legal, op} for an ALU funct3; sub requests SUB for funct3 000.
    function automatic logic [4:0] alu_map(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return {1'b1, sub ? 4'd1 : 4'd0};
            3'b111:  return {1'b1, 4'd2};
            3'b110:  return {1'b1, 4'd3};
            3'b010:  return {1'b1, 4'd4};
            default: return {1'b0, 4'd0};
        endcase
    endfunction

    // One clock: inputs driven just after the rising edge, outputs sampled on the falling edge.
    task automatic run_cycle(input string tag, input logic ready, input logic zero,
                             input logic [16:0] exp, input logic [16:0] mask, input bit retires);
        bus.i_memReady = ready;
        bus.i_zeroFlag = zero;
        @(negedge i_clk);
        check({tag, "_ctl"}, 32'(observed() & mask), 32'(exp & mask));
        check({tag, "_retire"}, 32'(bus.o_retireCount), 32'(exp_retire));
        @(posedge i_clk);
        #1;
        if (retires) exp_retire = (exp_retire + 1) % (1 << RW);
    endtask

    // Cycles with memory not ready; the TIMEOUT-th such cycle must carry no enables.
    task automatic wait_phase(input string tag, input logic [16:0] word, input int waits,
                              output bit timed_out);
        timed_out = 1'b0;
        for (int k = 0; k < waits; k++) begin
            if (k == TIMEOUT - 1) begin
                run_cycle({tag, "_timeout"}, 1'b0, rbit(), 17'h0, EN_MASK, 1'b0);
                timed_out = 1'b1;
                break;
            end
            run_cycle({tag, "_wait"}, 1'b0, rbit(), word, ALL, 1'b0);
        end
    endtask

    task automatic do_reset(input string tag);
        i_srst = 1'b1;
        bus.i_memReady = rbit();
        bus.i_zeroFlag = rbit();
        @(negedge i_clk);
        check({tag, "_rst_en"}, 32'(observed() & EN_MASK), 32'h0);
        @(posedge i_clk);
        #1;
        i_srst = 1'b0;
        exp_retire = 0;
    endtask

    task automatic trap_and_reset(input string tag);
        for (int k = 0; k < 3; k++)
            run_cycle({tag, "_trap"}, rbit(), rbit(), W_TRAP, ALL, 1'b0);
        do_reset(tag);
    endtask

    // Drive one instruction from FETCH to retirement (or trap) and check every cycle.
    task automatic run_instr(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                             input logic f7, input logic zero, input int fetch_wait,
                             input int mem_wait);
        logic [4:0] m;
        bit to;
        bit legal;
        bit taken;
        bus.i_opcode     = opc;
        bus.i_funct3     = f3;
        bus.i_funct7bit5 = f7;
        wait_phase({tag, "_fetch"}, W_FETCH_WAIT, fetch_wait, to);
        if (to) begin
            trap_and_reset(tag);
            return;
        end
        run_cycle({tag, "_fetch"}, 1'b1, rbit(), W_FETCH_DONE, ALL, 1'b0);
        run_cycle({tag, "_decode"}, rbit(), rbit(), W_DECODE, ALL, 1'b0);
        to = 1'b0;
        case (opc)
            OPC_LOAD: begin
                run_cycle({tag, "_memadr"}, rbit(), rbit(), W_MEMADR, ALL, 1'b0);
                wait_phase({tag, "_memread"}, W_MEMREAD, mem_wait, to);
                if (!to) begin
                    run_cycle({tag, "_memread"}, 1'b1, rbit(), W_MEMREAD, ALL, 1'b0);
                    run_cycle({tag, "_memwb"}, rbit(), rbit(), W_MEMWB, ALL, 1'b1);
                end
            end
            OPC_STORE: begin
                run_cycle({tag, "_memadr"}, rbit(), rbit(), W_MEMADR, ALL, 1'b0);
                wait_phase({tag, "_memwrite"}, W_MEMWRITE, mem_wait, to);
                if (!to) run_cycle({tag, "_memwrite"}, 1'b1, rbit(), W_MEMWRITE, ALL, 1'b1);
            end
            OPC_OP, OPC_OPIMM: begin
                m = alu_map(f3, (opc == OPC_OP) && f7);
                run_cycle({tag, "_exec"}, rbit(), rbit(),
                          {6'b0, 2'd2, (opc == OPC_OP) ? 2'd0 : 2'd1, m[3:0], 2'd0, 1'b0},
                          ALL, 1'b0);
                if (m[4]) run_cycle({tag, "_aluwb"}, rbit(), rbit(), W_ALUWB, ALL, 1'b1);
                else      to = 1'b1;
            end
            OPC_BRANCH: begin
                legal = (f3 == 3'b000) || (FB != 0 && f3 == 3'b001);
                taken = (f3 == 3'b000 && zero) || (FB != 0 && f3 == 3'b001 && !zero);
                run_cycle({tag, "_branch"}, rbit(), zero,
                          {taken, 5'b0, 2'd2, 2'd0, 4'd1, 2'd0, 1'b0}, ALL, legal);
                to = !legal;
            end
            OPC_JAL: run_cycle({tag, "_jal"}, rbit(), rbit(), W_JAL, ALL, 1'b1);
            default: to = 1'b1;
        endcase
        if (to) trap_and_reset(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] instr;
        logic [2:0]  legal_f3 [4];
        logic [6:0]  opc;
        logic [2:0]  f3;
        int          cls;
        legal_f3 = '{3'b000, 3'b111, 3'b110, 3'b010};

        bus.i_opcode     = '0;
        bus.i_funct3     = '0;
        bus.i_funct7bit5 = 1'b0;
        bus.i_zeroFlag   = 1'b0;
        bus.i_memReady   = 1'b0;
        @(posedge i_clk);
        #1;
        do_reset("init");

        // add x3, x1, x2: four cycles, retire count 0 -> 1
        instr = 32'h002081B3;
        run_instr("add", instr[6:0], instr[14:12], instr[30], 1'b0, 0, 0);
        check("add_retired", 32'(bus.o_retireCount), 32'd1);

        // sub and immediate forms
        run_instr("sub", OPC_OP, 3'b000, 1'b1, 1'b0, 1, 0);
        run_instr("addi_f7", OPC_OPIMM, 3'b000, 1'b1, 1'b0, 0, 0);

        // lw with three not-ready cycles in MEMREAD, then sw
        run_instr("lw_wait3", OPC_LOAD, 3'b010, 1'b0, 1'b0, 0, 3);
        run_instr("sw", OPC_STORE, 3'b010, 1'b0, 1'b0, 2, 1);

        // beq taken / not taken, then bne traps with beq-only branching
        run_instr("beq_taken", OPC_BRANCH, 3'b000, 1'b0, 1'b1, 0, 0);
        run_instr("beq_not", OPC_BRANCH, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr("bne_trap", OPC_BRANCH, 3'b001, 1'b0, 1'b0, 0, 0);
        check("bne_trap_cleared", 32'(bus.o_trap), 32'd0);

        // memory timeouts in FETCH and MEMWRITE
        run_instr("fetch_timeout", OPC_OP, 3'b000, 1'b0, 1'b0, TIMEOUT, 0);
        check("fetch_timeout_cleared", 32'(bus.o_trap), 32'd0);
        run_instr("sw_timeout", OPC_STORE, 3'b010, 1'b0, 1'b0, 0, TIMEOUT);
        run_instr("lw_near_timeout", OPC_LOAD, 3'b010, 1'b0, 1'b0, TIMEOUT - 1, TIMEOUT - 1);

        // illegal opcode and unsupported funct3
        run_instr("illegal_op", 7'h7F, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr("bad_f3", OPC_OPIMM, 3'b001, 1'b0, 1'b0, 0, 0);

        // retire counter wraps after 2**RW retirements
        do_reset("wrap");
        for (int i = 0; i < (1 << RW); i++)
            run_instr("jal", OPC_JAL, 3'($urandom), rbit(), rbit(), 0, 0);
        check("retire_wrap", 32'(bus.o_retireCount), 32'd0);

        // random instruction stream
        for (int n = 0; n < 250; n++) begin
            cls = $urandom_range(0, 9);
            f3  = legal_f3[$urandom_range(0, 3)];
            case (cls)
                0:       opc = OPC_LOAD;
                1:       opc = OPC_STORE;
                2, 3:    opc = OPC_OP;
                4, 5:    opc = OPC_OPIMM;
                6: begin
                    opc = OPC_BRANCH;
                    f3  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 1));
                end
                7:       opc = OPC_JAL;
                8: begin
                    opc = rbit() ? OPC_OP : OPC_OPIMM;
                    f3  = 3'($urandom);
                end
                default: opc = 7'($urandom);
            endcase
            run_instr("rnd", opc, f3, rbit(), rbit(),
                      $urandom_range(0, 4), $urandom_range(0, 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
